// File: rtl/video_palette_mapper.sv
// video_palette_mapper: 2-cycle pixel-to-RGB palette pipeline with data_io palette loader; SCANLINES_EN adds odd-line dimming
module video_palette_mapper #(
    parameter int         PIX_BITS    = 1,
    parameter int         NUM_PAL     = 4,
    parameter int         COLOR_DEPTH = 6,
    parameter logic [7:0] PAL_INDEX   = 8'h02,
    localparam int        PSW         = NUM_PAL > 1 ? $clog2(NUM_PAL) : 1
) (
    input  logic                   clk_sys,
    input  logic                   reset_n,
    input  logic [PIX_BITS-1:0]    pix_in,
    input  logic                   hs_in,
    input  logic                   vs_in,
    input  logic                   hb_in,
    input  logic                   vb_in,
    input  logic [PSW-1:0]         pal_sel,
`ifdef SCANLINES_EN
    input  logic [1:0]             scanlines,
`endif
    input  logic                   ioctl_download,
    input  logic                   ioctl_wr,
    input  logic [7:0]             ioctl_index,
    input  logic [7:0]             ioctl_dout,
    output logic [COLOR_DEPTH-1:0] r_out,
    output logic [COLOR_DEPTH-1:0] g_out,
    output logic [COLOR_DEPTH-1:0] b_out,
    output logic                   hs_out,
    output logic                   vs_out,
    output logic                   hb_out,
    output logic                   vb_out,
    output logic                   load_busy,
    output logic                   load_err
);
    localparam int CD      = COLOR_DEPTH;
    localparam int RW      = 3 * CD;
    localparam int ENTRIES = NUM_PAL << PIX_BITS;
    localparam int AW      = $clog2(ENTRIES);
    localparam int CW      = $clog2(ENTRIES + 1);

    typedef enum logic [1:0] {IDLE, LD_R, LD_G, LD_B} ld_state_t;

    function automatic logic [CD-1:0] sc(input logic [5:0] v);
        logic [7:0] t;
        t = {v, 2'b00};
        return t[7 -: CD];
    endfunction

    function automatic logic [RW-1:0] preset(input logic [AW-1:0] a);
        logic [1:0]  p;
        logic [17:0] c;
        p = 2'(a >> PIX_BITS);
        c = p == 2'd0 ? {6'h3F, 6'h3F, 6'h3F} :
            p == 2'd1 ? {6'h0D, 6'h3F, 6'h0D} :
            p == 2'd2 ? {6'h3F, 6'h33, 6'h00} : {6'h10, 6'h3F, 6'h29};
        return a[PIX_BITS-1:0] == '0 ? '0 : {sc(c[17:12]), sc(c[11:6]), sc(c[5:0])};
    endfunction

`ifdef SCANLINES_EN
    function automatic logic [CD-1:0] dim(input logic [CD-1:0] x, input logic [1:0] m);
        logic [CD+1:0] t3;
        t3 = {2'b00, x} + {1'b0, x, 1'b0};
        return m == 2'd1 ? t3[CD+1:2] : m == 2'd2 ? x >> 1 : m == 2'd3 ? x >> 2 : x;
    endfunction
`endif

    // RAM holds data XOR preset, so power-up zero contents read back as the preset palettes
    logic [RW-1:0] ram [ENTRIES];

    ld_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CD-1:0] r_q, r_d, g_q, g_d;
    logic          err_q, err_d;
    logic [PSW-1:0] pal_q, pal_d;
    logic          vs_prev_q, vs_prev_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [3:0]    sync1_q, sync1_d, sync2_q, sync2_d;
    logic [RW-1:0] rgb_q, rgb_d;
    logic          ram_we;
    logic [RW-1:0] ram_wdata, rd_word;
    logic [AW-1:0] waddr;
    logic [CD-1:0] chan;
    logic          active, vs_rise;
`ifdef SCANLINES_EN
    logic          hs_prev_q, hs_prev_d, par_q, par_d, par1_q, par1_d;
    logic [1:0]    sl_mode;
`endif

    assign active  = ioctl_download && ioctl_index == PAL_INDEX;
    assign chan    = ioctl_dout[7 -: CD];
    assign waddr   = AW'(cnt_q);
    assign vs_rise = vs_in & ~vs_prev_q;
    assign rd_word = ram[addr_q] ^ preset(addr_q);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        r_d       = r_q;
        g_d       = g_q;
        err_d     = err_q;
        ram_we    = 1'b0;
        ram_wdata = {r_q, g_q, chan};
        if (state_q == IDLE) begin
            if (active) begin
                state_d = LD_R;
                cnt_d   = '0;
                err_d   = 1'b0;
            end
        end else if (!active) begin
            state_d = IDLE;
            err_d   = err_q | (state_q != LD_R);
        end else if (ioctl_wr) begin
            if (cnt_q == CW'(ENTRIES)) begin
                err_d = 1'b1;
            end else if (state_q == LD_R) begin
                r_d     = chan;
                state_d = LD_G;
            end else if (state_q == LD_G) begin
                g_d     = chan;
                state_d = LD_B;
            end else begin
                ram_we  = 1'b1;
                cnt_d   = cnt_q + CW'(1);
                state_d = LD_R;
            end
        end
    end

    always_comb begin
        vs_prev_d = vs_in;
        pal_d     = vs_rise ? pal_sel : pal_q;
        addr_d    = AW'({pal_q, pix_in});
        sync1_d   = {hs_in, vs_in, hb_in, vb_in};
        sync2_d   = sync1_q;
`ifdef SCANLINES_EN
        hs_prev_d = hs_in;
        par_d     = vs_rise ? 1'b0 : (hs_in & ~hs_prev_q) ? ~par_q : par_q;
        par1_d    = par_q;
        sl_mode   = par1_q ? scanlines : 2'b00;
        rgb_d     = (sync1_q[1] | sync1_q[0]) ? '0 :
                    {dim(rd_word[RW-1 -: CD], sl_mode), dim(rd_word[2*CD-1 -: CD], sl_mode), dim(rd_word[CD-1:0], sl_mode)};
`else
        rgb_d     = (sync1_q[1] | sync1_q[0]) ? '0 : rd_word;
`endif
    end

    always_ff @(posedge clk_sys) begin
        if (ram_we) ram[waddr] <= ram_wdata ^ preset(waddr);
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            r_q       <= '0;
            g_q       <= '0;
            err_q     <= 1'b0;
            pal_q     <= '0;
            vs_prev_q <= 1'b0;
            addr_q    <= '0;
            sync1_q   <= '0;
            sync2_q   <= '0;
            rgb_q     <= '0;
`ifdef SCANLINES_EN
            hs_prev_q <= 1'b0;
            par_q     <= 1'b0;
            par1_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            r_q       <= r_d;
            g_q       <= g_d;
            err_q     <= err_d;
            pal_q     <= pal_d;
            vs_prev_q <= vs_prev_d;
            addr_q    <= addr_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            rgb_q     <= rgb_d;
`ifdef SCANLINES_EN
            hs_prev_q <= hs_prev_d;
            par_q     <= par_d;
            par1_q    <= par1_d;
`endif
        end
    end

    assign {r_out, g_out, b_out}          = rgb_q;
    assign {hs_out, vs_out, hb_out, vb_out} = sync2_q;
    assign load_busy = state_q != IDLE;
    assign load_err  = err_q;
endmodule

// File: tb/tb_video_palette_mapper.sv
// tb_video_palette_mapper: directed checks of colour pipeline, palette switching and loader
module tb_video_palette_mapper;
    logic       clk_sys = 1'b0;
    logic       reset_n = 1'b0;
    logic [0:0] pix_in = 1'b0;
    logic       hs_in = 1'b0, vs_in = 1'b0, hb_in = 1'b0, vb_in = 1'b0;
    logic [1:0] pal_sel = 2'd0;
    logic [1:0] scanlines = 2'd0;
    logic       ioctl_download = 1'b0, ioctl_wr = 1'b0;
    logic [7:0] ioctl_index = 8'h00, ioctl_dout = 8'h00;
    logic [5:0] r_out, g_out, b_out;
    logic       hs_out, vs_out, hb_out, vb_out, load_busy, load_err;
    logic [31:0] col, st;
    int passed = 0;
    int total = 0;

    video_palette_mapper dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .pix_in(pix_in),
        .hs_in(hs_in), .vs_in(vs_in), .hb_in(hb_in), .vb_in(vb_in), .pal_sel(pal_sel),
`ifdef SCANLINES_EN
        .scanlines(scanlines),
`endif
        .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
        .ioctl_index(ioctl_index), .ioctl_dout(ioctl_dout),
        .r_out(r_out), .g_out(g_out), .b_out(b_out),
        .hs_out(hs_out), .vs_out(vs_out), .hb_out(hb_out), .vb_out(vb_out),
        .load_busy(load_busy), .load_err(load_err)
    );

    always #5 clk_sys = ~clk_sys;

    assign col = {14'd0, r_out, g_out, b_out};
    assign st  = {26'd0, hs_out, vs_out, hb_out, vb_out, load_busy, load_err};

    function automatic logic [31:0] rgb(input logic [5:0] r, input logic [5:0] g, input logic [5:0] b);
        return {14'd0, r, g, b};
    endfunction

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic show(input logic p);
        pix_in = p;
        tick();
        tick();
    endtask

    task automatic vpulse();
        vs_in = 1'b1;
        tick();
        vs_in = 1'b0;
        tick();
        tick();
    endtask

    task automatic send(input logic [7:0] b);
        ioctl_wr   = 1'b1;
        ioctl_dout = b;
        tick();
        ioctl_wr   = 1'b0;
        tick();
    endtask

    task automatic up_start();
        ioctl_index    = 8'h02;
        ioctl_download = 1'b1;
        tick();
    endtask

    task automatic up_end();
        ioctl_download = 1'b0;
        tick();
    endtask

    initial begin
        tick();
        tick();
        chk("reset_rgb", col, 32'd0);
        chk("reset_status", st, 32'd0);
        reset_n = 1'b1;
        show(1'b0);
        pix_in = 1'b1;
        hs_in  = 1'b1;
        tick();
        chk("latency_1cycle", col, 32'd0);
        hs_in = 1'b0;
        tick();
        chk("white_pix1", col, rgb(6'h3F, 6'h3F, 6'h3F));
        chk("hs_delay", st, 32'b100000);
        show(1'b0);
        chk("black_pix0", col, 32'd0);
        hb_in = 1'b1;
        show(1'b1);
        chk("hblank_zero", col, 32'd0);
        chk("hb_delay", st, 32'b001000);
        hb_in = 1'b0;
`ifdef SCANLINES_EN
        scanlines = 2'b10;
        vpulse();
        show(1'b1);
        chk("sl_even", col, rgb(6'h3F, 6'h3F, 6'h3F));
        hs_in = 1'b1;
        tick();
        hs_in = 1'b0;
        tick();
        tick();
        chk("sl_odd_half", col, rgb(6'h1F, 6'h1F, 6'h1F));
        scanlines = 2'b01;
        tick();
        chk("sl_odd_3q", col, rgb(6'h2F, 6'h2F, 6'h2F));
        scanlines = 2'b11;
        tick();
        chk("sl_odd_q", col, rgb(6'h0F, 6'h0F, 6'h0F));
        scanlines = 2'b00;
        tick();
        chk("sl_off", col, rgb(6'h3F, 6'h3F, 6'h3F));
        scanlines = 2'b10;
        hb_in = 1'b1;
        show(1'b1);
        chk("sl_blank", col, 32'd0);
        hb_in = 1'b0;
        vpulse();
        chk("sl_vs_clear", col, rgb(6'h3F, 6'h3F, 6'h3F));
        scanlines = 2'b00;
`endif
        pal_sel = 2'd2;
        pix_in  = 1'b1;
        tick();
        tick();
        tick();
        chk("mid_frame_white", col, rgb(6'h3F, 6'h3F, 6'h3F));
        vs_in = 1'b1;
        tick();
        vs_in = 1'b0;
        tick();
        chk("vs_delay", st, 32'b010000);
        chk("no_tear", col, rgb(6'h3F, 6'h3F, 6'h3F));
        tick();
        chk("amber", col, rgb(6'h3F, 6'h33, 6'h00));
        pal_sel = 2'd1;
        vpulse();
        chk("green", col, rgb(6'h0D, 6'h3F, 6'h0D));
        pal_sel = 2'd3;
        vpulse();
        chk("cyan", col, rgb(6'h10, 6'h3F, 6'h29));

        ioctl_index    = 8'h01;
        ioctl_download = 1'b1;
        tick();
        chk("other_index_idle", st, 32'd0);
        send(8'hFF);
        ioctl_download = 1'b0;
        tick();

        pal_sel = 2'd0;
        vpulse();
        up_start();
        chk("busy_during", st, 32'b000010);
        send(8'h00); send(8'h00); send(8'h00);
        send(8'hFC); send(8'h80); send(8'h40);
        up_end();
        chk("busy_after", st, 32'd0);
        show(1'b1);
        chk("uploaded_e1", col, rgb(6'h3F, 6'h20, 6'h10));
        show(1'b0);
        chk("uploaded_e0", col, 32'd0);

        up_start();
        send(8'h00); send(8'h00); send(8'h00);
        send(8'h40); send(8'h80); send(8'hC0);
        send(8'hFF);
        up_end();
        chk("short_err", st, 32'b000001);
        show(1'b1);
        chk("short_e1", col, rgb(6'h10, 6'h20, 6'h30));
        up_start();
        chk("err_cleared", st, 32'b000010);
        send(8'h00); send(8'h00); send(8'h00);
        send(8'hFC); send(8'hFC); send(8'hFC);
        up_end();
        chk("valid_no_err", st, 32'd0);

        up_start();
        for (int i = 0; i < 8; i++) begin
            send({6'(i + 1), 2'b00});
            send({6'(i + 16), 2'b00});
            send({6'(i + 32), 2'b00});
        end
        send(8'hFF);
        send(8'hFF);
        up_end();
        chk("long_err", st, 32'b000001);
        pal_sel = 2'd3;
        vpulse();
        show(1'b1);
        chk("ram7_intact", col, rgb(6'h08, 6'h17, 6'h27));
        show(1'b0);
        chk("ram6", col, rgb(6'h07, 6'h16, 6'h26));

        up_start();
        send(8'h40);
        send(8'h40);
        reset_n        = 1'b0;
        ioctl_download = 1'b0;
        #1;
        chk("reset_mid_upload", st, 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        show(1'b1);
        chk("ram_kept_after_reset", col, rgb(6'h02, 6'h11, 6'h21));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
